// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC blocks.
// Angles use 16-bit full circle; datapath is 18-bit signed.
package cordic_pkg;
   localparam int MAX_ITER = 16;
   localparam int K_SCALE  = 39797;
   localparam int ANGLE_W  = 16;
   localparam int DATA_W   = 18;

   typedef enum logic {
      IDLE,
      ITER
   } state_t;

   localparam logic [ANGLE_W-1:0] OFS_Q0 = 16'h0000;
   localparam logic [ANGLE_W-1:0] OFS_Q2 = 16'h8000;
endpackage

// File: rtl/gamma_mem.sv
// gamma_mem: atan(2^-i) table, 2^16 per pi/2, zero for i >= 17.
// Ports: iter (5-bit index) in, gamma (16-bit unsigned) out.
module gamma_mem (
   input  logic [4:0]  iter,
   output logic [15:0] gamma
);

   always_comb begin
      gamma = 16'd0;
      case (iter)
         5'd0:    gamma = 16'd32768;
         5'd1:    gamma = 16'd19344;
         5'd2:    gamma = 16'd10221;
         5'd3:    gamma = 16'd5188;
         5'd4:    gamma = 16'd2604;
         5'd5:    gamma = 16'd1303;
         5'd6:    gamma = 16'd652;
         5'd7:    gamma = 16'd326;
         5'd8:    gamma = 16'd163;
         5'd9:    gamma = 16'd81;
         5'd10:   gamma = 16'd41;
         5'd11:   gamma = 16'd20;
         5'd12:   gamma = 16'd10;
         5'd13:   gamma = 16'd5;
         5'd14:   gamma = 16'd3;
         5'd15:   gamma = 16'd1;
         5'd16:   gamma = 16'd1;
         default: gamma = 16'd0;
      endcase
   end

endmodule

// File: rtl/cordic_vec.sv
// cordic_vec: iterative vectoring CORDIC, (x,y) -> atan2 angle and magnitude.
// Ports: clk, rst, x, y, in_valid, ready, out_valid, theta, mag.
module cordic_vec #(
   parameter int MAX_ITER = cordic_pkg::MAX_ITER,
   parameter int K_SCALE  = cordic_pkg::K_SCALE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] x,
   input  logic signed [15:0] y,
   input  logic               in_valid,
   output logic               ready,
   output logic               out_valid,
   output logic [15:0]        theta,
   output logic [15:0]        mag
);

   import cordic_pkg::*;

   localparam int IW = $clog2(MAX_ITER + 1);

   state_t state;
   state_t state_nxt;

   logic [IW-1:0]            iter;
   logic signed [DATA_W-1:0] xr;
   logic signed [DATA_W-1:0] yr;
   logic signed [DATA_W-1:0] zr;
   logic [ANGLE_W-1:0]       offset;
   logic                     zero;

   logic                     accept;
   logic                     last;
   logic signed [DATA_W-1:0] x_ext;
   logic signed [DATA_W-1:0] y_ext;
   logic signed [DATA_W-1:0] xs;
   logic signed [DATA_W-1:0] ys;
   logic [15:0]              gam;
   logic signed [DATA_W-1:0] gam_ext;
   logic signed [DATA_W-1:0] z_rnd;
   logic [33:0]              prod;
   logic [ANGLE_W-1:0]       th_fin;
   logic                     unused_bits;

   gamma_mem u_gamma (
      .iter  (5'(iter)),
      .gamma (gam)
   );

   assign accept  = in_valid && (state == IDLE);
   assign last    = (iter == IW'(MAX_ITER));
   assign x_ext   = DATA_W'(x);
   assign y_ext   = DATA_W'(y);
   assign xs      = xr >>> iter;
   assign ys      = yr >>> iter;
   assign gam_ext = $signed({2'b00, gam});

   // zr carries 2 extra fraction bits; round then drop them
   assign z_rnd  = zr + 18'sd2;
   assign th_fin = offset + z_rnd[17:2];

   // xr is non-negative after the fold and stays so
   assign prod = 34'($unsigned(xr)) * 34'(K_SCALE);

   assign unused_bits = ^{prod[33:32], prod[15:0], z_rnd[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid) state_nxt = ITER;
         ITER: if (last)     state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iter      <= '0;
         xr        <= '0;
         yr        <= '0;
         zr        <= '0;
         offset    <= OFS_Q0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
         theta     <= '0;
         mag       <= '0;
      end else if (accept) begin
         // fold left half-plane onto the right, remember pi offset
         if (x < 0) begin
            xr     <= -x_ext;
            yr     <= -y_ext;
            offset <= OFS_Q2;
         end else begin
            xr     <= x_ext;
            yr     <= y_ext;
            offset <= OFS_Q0;
         end
         zr        <= '0;
         iter      <= '0;
         zero      <= (x == 16'sd0) && (y == 16'sd0);
         out_valid <= 1'b0;
         theta     <= '0;
         mag       <= '0;
      end else if (state == ITER) begin
         if (last) begin
            theta     <= zero ? '0 : th_fin;
            mag       <= zero ? '0 : prod[31:16];
            out_valid <= 1'b1;
            iter      <= '0;
         end else begin
            if (yr >= 0) begin
               xr <= xr + ys;
               yr <= yr - xs;
               zr <= zr + gam_ext;
            end else begin
               xr <= xr - ys;
               yr <= yr + xs;
               zr <= zr - gam_ext;
            end
            iter <= iter + 1'b1;
         end
      end
   end

endmodule
